// File: rtl/hann_window_pkg.sv
// Shared constants for the Hann windowing stage, plus the constant function
// used to fill the coefficient ROM at elaboration.
package hann_window_pkg;

  localparam int FRAME_LEN = 128;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int GRP_W     = 7;
  localparam int IN_IDX_W  = 10;

  localparam longint ONE_Q30     = 64'sd1073741824;
  localparam longint PI_HALF_Q30 = 64'sd1686629713;

  // Q30 Taylor cosine over [0, pi/2]; the upper quarter is folded onto it so
  // the series always converges fast and stays inside 64-bit products.
  function automatic longint hann_coef(input int n, input int cbw);
    longint x, x2, term, c, v;
    int     m;
    bit     neg;
    if (n <= FRAME_LEN / 4) begin
      m   = n;
      neg = 1'b0;
    end else begin
      m   = FRAME_LEN / 2 - n;
      neg = 1'b1;
    end
    x    = (PI_HALF_Q30 * longint'(m)) / longint'(FRAME_LEN / 4);
    x2   = (x * x) >>> 30;
    term = ONE_Q30;
    c    = term;
    for (int k = 1; k <= 12; k++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * k - 1) * (2 * k)));
      c    = c + term;
    end
    if (neg) c = -c;
    v = ((ONE_Q30 - c) + (longint'(1) <<< (30 - cbw))) >>> (31 - cbw);
    if (v > (longint'(1) <<< cbw) - 1) v = (longint'(1) <<< cbw) - 1;
    if (v < 0) v = 0;
    return v;
  endfunction

endpackage

// File: rtl/hann_window_if.sv
// Sample stream into and out of the Hann windowing stage.
interface hann_window_if
  import hann_window_pkg::*;
#(
  parameter int I_BW = 14,
  parameter int O_BW = 16
);
  logic                       di_en;
  logic signed [I_BW-1:0]     data_i;
  logic        [IN_IDX_W-1:0] in_idx;
  logic        [GRP_W-1:0]    in_group_num;
  logic                       err_clr;

  logic                       do_en;
  logic signed [O_BW-1:0]     data_o;
  logic        [IDX_W-1:0]    out_pos;
  logic        [GRP_W-1:0]    out_group_num;
  logic                       frame_start;
  logic                       frame_end;
  logic                       err_seq;

  modport master (
    output di_en, data_i, in_idx, in_group_num, err_clr,
    input  do_en, data_o, out_pos, out_group_num, frame_start, frame_end, err_seq
  );

  modport slave (
    input  di_en, data_i, in_idx, in_group_num, err_clr,
    output do_en, data_o, out_pos, out_group_num, frame_start, frame_end, err_seq
  );
endinterface

// File: rtl/hann_window_coef_rom.sv
// Half-period Hann coefficient table with mirrored addressing; purely
// combinational, the caller registers the result.
module hann_coef_rom
  import hann_window_pkg::*;
#(
  parameter int C_BW = 16
) (
  input  logic [IDX_W-1:0] idx,
  output logic [C_BW-1:0]  coef
);
  localparam int HALF = FRAME_LEN / 2;

  logic [C_BW-1:0]  rom [HALF+1];
  logic [IDX_W-1:0] m;

  for (genvar i = 0; i <= HALF; i++) begin : g_rom
    localparam logic [C_BW-1:0] W = C_BW'(hann_coef(i, C_BW));
    assign rom[i] = W;
  end

  // Modular negate gives FRAME_LEN - idx in IDX_W bits for the upper half.
  always_comb begin
    m = idx;
    if (idx > IDX_W'(HALF)) m = IDX_W'(0) - idx;
  end

  assign coef = rom[m];

endmodule

// File: rtl/hann_window.sv
// Two-stage Hann windowing: coefficient lookup, then multiply, round half up
// and saturate, with frame tags and a sticky sequence-error flag.
module hann_window
  import hann_window_pkg::*;
#(
  parameter int I_BW = 14,
  parameter int O_BW = 16,
  parameter int C_BW = 16
) (
  input logic          clk,
  input logic          rst,
  hann_window_if.slave bus
);
  localparam int STAGES = 2;
  localparam int SH     = C_BW - (O_BW - I_BW);
  localparam int PW     = I_BW + C_BW + 1;
  localparam int RW     = O_BW + 1;

  localparam logic signed [PW-1:0]   RND   = PW'(1) <<< (SH - 1);
  localparam logic signed [O_BW-1:0] O_MAX = {1'b0, {(O_BW-1){1'b1}}};
  localparam logic signed [O_BW-1:0] O_MIN = {1'b1, {(O_BW-1){1'b0}}};

  logic [STAGES-1:0]      vld_pipe;
  logic [IDX_W-1:0]       n;
  logic [IDX_W-1:0]       exp_pos;
  logic [C_BW-1:0]        rom_coef;
  logic                   err_new;

  logic signed [I_BW-1:0] s1_data;
  logic        [C_BW-1:0] s1_coef;
  logic [IDX_W-1:0]       s1_pos;
  logic [GRP_W-1:0]       s1_grp;

  logic signed [O_BW-1:0] s2_data;
  logic [IDX_W-1:0]       s2_pos;
  logic [GRP_W-1:0]       s2_grp;
  logic                   s2_fs, s2_fe, err_q;

  logic signed [C_BW:0]   coef_ext;
  logic signed [PW-1:0]   prod, rnd;
  logic signed [RW-1:0]   shf;
  logic signed [O_BW-1:0] sat;

  assign n = bus.in_idx[IDX_W-1:0];

  hann_coef_rom #(.C_BW(C_BW)) u_rom (
    .idx  (n),
    .coef (rom_coef)
  );

  // Out-of-range indices never equal exp_pos, but the explicit range test
  // keeps intent visible if the compare widths ever change.
  assign err_new = bus.di_en &&
                   ((bus.in_idx != IN_IDX_W'(exp_pos)) ||
                    (bus.in_idx >= IN_IDX_W'(FRAME_LEN)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      exp_pos  <= '0;
      err_q    <= 1'b0;
      s1_data  <= '0;
      s1_coef  <= '0;
      s1_pos   <= '0;
      s1_grp   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], bus.di_en};
      if (err_new)          err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
      if (bus.di_en) begin
        exp_pos <= n + IDX_W'(1);
        s1_data <= bus.data_i;
        s1_coef <= rom_coef;
        s1_pos  <= n;
        s1_grp  <= bus.in_group_num;
      end
    end
  end

  // The shifted result is always O_BW+1 bits, so one sign-bit compare
  // detects overflow of the output range.
  always_comb begin
    coef_ext = {1'b0, s1_coef};
    prod     = PW'(s1_data) * PW'(coef_ext);
    rnd      = prod + RND;
    shf      = RW'(rnd >>> SH);
    sat      = shf[O_BW-1:0];
    if (shf[RW-1] != shf[RW-2]) sat = shf[RW-1] ? O_MIN : O_MAX;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_data <= '0;
      s2_pos  <= '0;
      s2_grp  <= '0;
      s2_fs   <= 1'b0;
      s2_fe   <= 1'b0;
    end else begin
      s2_fs <= vld_pipe[0] && (s1_pos == '0);
      s2_fe <= vld_pipe[0] && (s1_pos == IDX_W'(FRAME_LEN - 1));
      if (vld_pipe[0]) begin
        s2_data <= sat;
        s2_pos  <= s1_pos;
        s2_grp  <= s1_grp;
      end
    end
  end

  assign bus.do_en         = vld_pipe[STAGES-1];
  assign bus.data_o        = s2_data;
  assign bus.out_pos       = s2_pos;
  assign bus.out_group_num = s2_grp;
  assign bus.frame_start   = s2_fs;
  assign bus.frame_end     = s2_fe;
  assign bus.err_seq       = err_q;

endmodule
